mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported 1024 x 32 pipeline memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (LW/SW data access).
- Accepts one access at a time, sequences the memory through a configurable access latency, and returns read data or a write acknowledge to the winning requester.
- Sits between the pipeline and the memory array. It replaces direct array indexing by both stages.

Parameters:
AW, 10, memory word-address width
DW, 32, data width
MEM_LAT, 1, memory access cycles per transaction (>=1)
MAX_DSTREAK, 4, max consecutive data grants while IF waits (used only with MEMARB_FAIR_EN)

Ports:
clk1  in  1  single clock for the block, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetched instruction
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data word address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid / store complete
d_rdata  out  DW  load data
mem_en  out  1  memory enable
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid in last ACCESS cycle
busy  out  1  state != IDLE

Behaviour:
- Interface: single clock clk1; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, latency counter 0, streak counter 0, captured address/data/we/owner 0.
- Reset mid-access drops the in-flight transaction. No rvalid is produced for it after reset release.
- States:
  - IDLE -> ACCESS on any grant.
  - ACCESS stays for MEM_LAT cycles, then goes to IDLE.
- Grant (combinational, IDLE only):
  - At most one of if_gnt/d_gnt is high per cycle.
  - Handshake completes when req & gnt are both high. Addr, we and wdata are captured on that edge.
  - Inputs need not stay stable after the grant.
  - A request deasserted before its grant has no effect.
- Priority: d_req beats if_req (older instruction first).
- ACCESS:
  - mem_en = 1 with the captured address.
  - mem_we = captured we in the first ACCESS cycle only.
  - mem_wdata = captured wdata.
  - Down-counter loads MEM_LAT-1 and decrements. Exit when the counter reaches 0.
- Response:
  - On the last ACCESS edge, mem_rdata is registered into the owner's rdata (loads/fetches only). Stores leave d_rdata unchanged.
  - Owner's rvalid pulses for exactly one cycle, the first IDLE cycle. A new grant may occur in that same cycle.
- Timing: accept at cycle T -> mem_en T+1..T+MEM_LAT -> rvalid at T+MEM_LAT+1. Max throughput is one access per MEM_LAT+1 cycles.
- if_rdata/d_rdata hold their last value until the next read for that port completes.
- Outputs mem_en/mem_we/mem_addr/mem_wdata come from state and registers. No combinational path from req inputs to the memory interface.

Optional Feature:
- Macro MEMARB_FAIR_EN.
- Defined:
  - Streak counter increments on each d_gnt issued while if_req is high.
  - It clears on if_gnt or on any IDLE cycle with if_req low.
  - When streak == MAX_DSTREAK and if_req is high, IF wins over d_req. The next grant then reverts to data priority.
- Undefined:
  - Strict data priority. IF may starve under continuous d_req.
  - No streak logic is synthesized.

Test Plan:
1. MEM_LAT=1, mem[5]=0xDEADBEEF, if_req addr 5 at cycle 0 -> if_gnt cycle 0, mem_en/mem_addr=5 cycle 1, if_rvalid=1 and if_rdata=0xDEADBEEF cycle 2, busy high cycle 1 only.
2. if_req addr 2 and d_req load addr 7 in the same cycle -> d_gnt first, if_gnt at cycle MEM_LAT+1, d_rvalid before if_rvalid, no cycle with both gnts high.
3. Store d_we=1 addr 1023 data 0x12345678 -> mem_we high exactly 1 cycle, d_rvalid pulse, d_rdata unchanged. Following load addr 1023 returns 0x12345678.
4. MEM_LAT=3, back-to-back data loads held continuously -> d_gnt every 4 cycles, d_rvalid spacing 4 cycles, mem_en high 3 of every 4 cycles.
5. MEMARB_FAIR_EN, MAX_DSTREAK=4, d_req and if_req held high -> exactly 4 d_gnt then 1 if_gnt, repeating. Without the macro, no if_gnt within 50 cycles.
6. rst_n low during the second ACCESS cycle (MEM_LAT=3) -> all outputs 0 immediately without clock. After release, no rvalid, busy=0, and a new request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two requester ports (instruction fetch and data access) and
//   the single-ported memory bus that mem_port_arbiter sits between.
//
//   Signals
//     if_req/if_addr            fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata fetch accept, response pulse, instruction
//     d_req/d_we/d_addr/d_wdata data request (held until d_gnt)
//     d_gnt/d_rvalid/d_rdata    data accept, response pulse, load data
//     mem_en/mem_we/mem_addr/mem_wdata  memory command
//     mem_rdata                 memory read data (valid in last access cycle)
//
//   Modports
//     slave  : arbiter view (requests and mem_rdata in, everything else out)
//     master : pipeline + memory view (mirror of slave)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported AW x DW memory between the IF stage (fetch,
//   read-only) and the MEM stage (loads/stores). One access is in flight at a
//   time: a grant in IDLE captures the request, the memory is driven for
//   MEM_LAT cycles, and the owner gets a one-cycle rvalid in the first IDLE
//   cycle afterwards (a new grant can happen in that same cycle).
//
//   Ports
//     clk1   : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : mem_port_arbiter_if.slave (requester ports + memory bus)
//     busy   : high whenever an access is in progress
//
//   Optional feature (macro MEMARB_FAIR_EN)
//     When defined, a streak counter limits the number of consecutive data
//     grants while IF is waiting to MAX_DSTREAK; IF then wins one grant.
//     When undefined, data always has priority and no streak logic exists.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                clk1,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MAX_DSTREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT and MAX_DSTREAK must be >= 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;      // 1 = data port owns the access
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          if_gnt;
    logic          d_gnt;
    logic          if_wins;               // fairness override of data priority

`ifdef MEMARB_FAIR_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    assign if_wins = bus.if_req && (streak_q == SW'(MAX_DSTREAK));

    // Counts data grants that made a waiting fetch wait longer. It can never
    // pass MAX_DSTREAK: at that value a waiting fetch takes the next grant.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && bus.if_req) begin
            streak_d = streak_q + SW'(1);
        end else if ((state_q == IDLE) && !bus.if_req) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign if_wins = 1'b0;
`endif

    // Grants are only issued in IDLE, so at most one is ever high.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state_q == IDLE) begin
            if (if_wins) begin
                if_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        owner_d     = owner_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    we_d    = bus.d_we;
                    owner_d = 1'b1;
                end else if (if_gnt) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    owner_d = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last access cycle: mem_rdata is valid now.
                    state_d = IDLE;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Memory command depends only on registered state; the counter still
    // holds its load value in the first access cycle, which marks the
    // single cycle the write strobe is allowed.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q && (cnt_q == CNT_LOAD);
    assign bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;

    assign busy = (state_q != IDLE);
endmodule
